jesd204b_dll_tx_ctrl: RTL
=========================

// Module: jesd204b_dll_tx_ctrl
// PURPOSE
//  Data-link-layer sequencer for the JESD204B TX path, between jesd204b_tpl_tx and the 8b/10b encoders.
//  Runs the link bring-up: Code Group Sync (CGS), then the 4-multiframe Initial Lane Alignment Sequence (ILAS), then user data.
//  The SYNC~ handshake from the receiver drives the sequence; multiframe boundaries come from a local LMFC counter.
//  Scrambling and character replacement are not used (SCR=0).
// PARAMETERS
//  LANES      4    lanes (L); each lane carries 4 octets per clk
//  OCTETS     4    octets per frame per lane (F)
//  FRAMES_MF  32   frames per multiframe (K); legal 17..32; K*F must be divisible by 4
//  CONVERTERS 8    M, reported in ILAS config
//  RESOLUTION 11   N, reported in ILAS config
//  SAMPLE_SIZE 16  N', reported in ILAS config
//  CONTROL    2    CS, reported in ILAS config
//  SAMPLES    1    S, reported in ILAS config
//  DID        8'h00  device ID;  BID  4'h0  bank ID
// PORTS
//  clk          in   1          link clock; one 4-octet word per lane per cycle
//  rst          in   1          synchronous, active-high reset
//  sync_n       in   1          SYNC~ from RX, active low, already synchronised to clk
//  tx_datain    in   LANES*32   transport-layer words; lane i = [i*32 +: 32], octet 0 = [31:24]
//  tx_dataout   out  LANES*32   octets to 8b/10b encoders; same lane and octet ordering as tx_datain
//  tx_charisk   out  LANES*4    K-char flag per octet; bit 3 of each lane nibble = octet 0
//  tpl_ready    out  1          high while tx_datain is consumed (state DATA)
//  link_state   out  2          0=CGS, 1=ILAS, 2=DATA
//  lmfc_cnt     out  clog2(MF)  LMFC position, MF = FRAMES_MF*OCTETS/4 clocks
// BEHAVIOUR
//  Reset values:
//   - Registers: state=CGS, lmfc_cnt=0, mf_idx=0, sync-loss count=0.
//   - Outputs, first cycle after reset: tx_dataout=all 8'hBC, tx_charisk=all 1, tpl_ready=0, link_state=0.
//  Output timing: all outputs are registered. Output in cycle n+1 encodes the state and lmfc_cnt of cycle n.
//  DATA-path latency, tx_datain to tx_dataout: 1 clk.
//  LMFC counter:
//   - Free-running 0..MF-1, wraps to 0.
//   - Starts at 0 after reset and is never stopped by state changes.
//  Octet position within a multiframe: p = lmfc_cnt*4 + j, j = 0..3 octet within the word.
//  CGS:
//   - Every octet is K28.5 (8'hBC, k=1).
//   - If sync_n==1 in a cycle with lmfc_cnt==MF-1, the next state is ILAS with mf_idx=0.
//   - sync_n==1 at any other lmfc_cnt waits for the next boundary.
//  ILAS (mf_idx 0..3, incremented at each wrap of lmfc_cnt):
//   - p==0: /R/ K28.0 (8'h1C, k=1).
//   - p==MF*4-1: /A/ K28.3 (8'h7C, k=1).
//   - mf_idx==1 and p==1: /Q/ K28.4 (8'h9C, k=1).
//   - mf_idx==1 and p==2..15: 14 config octets, k=0, in this order:
//     DID, BID, LID (=lane idx), {SCR=0,L-1}, F-1, K-1, M-1, {CS,N-1}, {subclass=0,N'-1}, {JESDV=1,S-1}, {HD=0,CF=0}, RES1=0, RES2=0, FCHK.
//   - FCHK = sum of the first 11 config octets (DID through {HD,CF}) mod 256, computed per lane.
//   - All other octets: ramp p[7:0], k=0.
//   - After the cycle with mf_idx==3 and lmfc_cnt==MF-1, the next state is DATA.
//  DATA:
//   - tx_dataout = tx_datain registered; tx_charisk=0; tpl_ready=1.
//  Sync loss (state ILAS or DATA):
//   - sync_n low for 4 consecutive cycles -> state=CGS in the next cycle, independent of LMFC.
//   - Lower tpl_ready in that same cycle.
//   - Low pulses shorter than 4 cycles are ignored and clear the counter.
//  In CGS, sync_n low simply holds CGS.
//  rst asserted mid-ILAS or mid-DATA: next cycle matches the reset values; no partial multiframe completes.
//  Simultaneous rst and sync_n events: rst wins.
//  Widths: config fields are truncated to their JESD204B field widths, e.g. F-1 and K-1 use 8 bits, N-1 uses 5 bits.
// STRUCTURE
//  Shared package jesd204b_pkg:
//   - K-char constants K28_5/K28_0/K28_3/K28_4.
//   - link_state encoding.
//   - Function ilas_cfg_octet(idx,lane) and function fchk.
//  One sub-module: jesd204b_lmfc_cnt (counter plus wrap pulse), reusable by the RX side.
//  Octet muxing per lane is a generate loop in this block.
// TESTING
//  Defaults, rst 3 clks, sync_n=0 ->
//   - all lanes 32'hBCBCBCBC, charisk 4'hF, link_state=0, tpl_ready=0 indefinitely.
//  Raise sync_n at lmfc_cnt=3 (MF=32) ->
//   - ILAS starts at the next lmfc_cnt=0; first word 32'h1C010203, charisk 4'h8.
//  ILAS mf_idx=1 ->
//   - lane 2 word 0 = 32'h1C9C0000, charisk 4'hC.
//   - word 1 = {8'h02, 8'h03, 8'h03, 8'h1F}, i.e. {LID, L-1, F-1, K-1}.
//   - FCHK = byte sum of config octets 0..10; last word of each MF ends in 8'h7C.
//  After 4*32 ILAS clks ->
//   - link_state=2, tpl_ready=1.
//   - tx_datain=32'hDEADBEEF per lane appears on tx_dataout 1 clk later with charisk=0.
//  In DATA, sync_n low for 3 clks then high ->
//   - stays in DATA.
//   - low for 4 clks -> CGS (8'hBC) next cycle; re-sync realigns ILAS to LMFC.
//  rst asserted mid-ILAS (mf_idx=2) ->
//   - next cycle: CGS, lmfc_cnt=0, all outputs at their reset values.

Source files
------------

// File: rtl/jesd204b_pkg.sv
// ---------------------------------------------------------------------------
// jesd204b_pkg
// Shared JESD204B link-layer definitions for the TX and RX data-link blocks:
//   - K-character constants (K28.5 /K/, K28.0 /R/, K28.3 /A/, K28.4 /Q/)
//   - link_state encoding
//   - ILAS link-configuration record and the per-lane config octet / FCHK
//     helpers
// No ports (package).
// ---------------------------------------------------------------------------
package jesd204b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_e;

  // Link parameters already reduced to their ILAS field widths (minus-one
  // fields hold the value-1 as carried on the wire).
  typedef struct packed {
    logic [7:0] did;
    logic [3:0] bid;
    logic [4:0] l_m1;
    logic [7:0] f_m1;
    logic [7:0] k_m1;
    logic [7:0] m_m1;
    logic [1:0] cs;
    logic [4:0] n_m1;
    logic [4:0] np_m1;
    logic [4:0] s_m1;
  } jesd_cfg_t;

  // Config octets 0..12 (everything except FCHK).
  function automatic logic [7:0] cfg_field(jesd_cfg_t c, logic [3:0] idx,
                                           logic [4:0] lane);
    logic [7:0] o;
    case (idx)
      4'd0:    o = c.did;
      4'd1:    o = {4'h0, c.bid};
      4'd2:    o = {3'b000, lane};
      4'd3:    o = {3'b000, c.l_m1};     // SCR=0
      4'd4:    o = c.f_m1;
      4'd5:    o = c.k_m1;
      4'd6:    o = c.m_m1;
      4'd7:    o = {c.cs, 1'b0, c.n_m1};
      4'd8:    o = {3'b000, c.np_m1};    // subclass 0
      4'd9:    o = {3'b001, c.s_m1};     // JESDV=1
      default: o = 8'h00;                // {HD,CF}, RES1, RES2
    endcase
    return o;
  endfunction

  // FCHK: mod-256 sum of octets DID..{HD,CF}.
  function automatic logic [7:0] fchk(jesd_cfg_t c, logic [4:0] lane);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 11; i++) s = s + cfg_field(c, 4'(i), lane);
    return s;
  endfunction

  function automatic logic [7:0] ilas_cfg_octet(jesd_cfg_t c, logic [3:0] idx,
                                                logic [4:0] lane);
    return (idx == 4'd13) ? fchk(c, lane) : cfg_field(c, idx, lane);
  endfunction

endpackage

// File: rtl/jesd204b_dll_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// jesd204b_dll_tx_ctrl_if
// Bundle between the TX data-link controller and its neighbours.
//   sync_n      SYNC~ from the receiver (active low, clk-synchronous)
//   tx_datain   transport-layer words, lane i = [i*32 +: 32], octet 0 = MSB
//   tx_dataout  octets to the 8b/10b encoders, same ordering
//   tx_charisk  K flag per octet, bit 3 of each lane nibble = octet 0
//   tpl_ready   tx_datain is being consumed
//   link_state  0=CGS 1=ILAS 2=DATA
//   lmfc_cnt    local multiframe position
// slave = the controller, master = the surrounding logic.
// ---------------------------------------------------------------------------
interface jesd204b_dll_tx_ctrl_if #(
  parameter int LANES  = 4,
  parameter int LMFC_W = 5
);
  logic                  sync_n;
  logic [LANES*32-1:0]   tx_datain;
  logic [LANES*32-1:0]   tx_dataout;
  logic [LANES*4-1:0]    tx_charisk;
  logic                  tpl_ready;
  logic [1:0]            link_state;
  logic [LMFC_W-1:0]     lmfc_cnt;

  modport master (
    output sync_n, tx_datain,
    input  tx_dataout, tx_charisk, tpl_ready, link_state, lmfc_cnt
  );

  modport slave (
    input  sync_n, tx_datain,
    output tx_dataout, tx_charisk, tpl_ready, link_state, lmfc_cnt
  );
endinterface

// File: rtl/jesd204b_lmfc_cnt.sv
// ---------------------------------------------------------------------------
// jesd204b_lmfc_cnt
// Free-running local multiframe clock counter, 0..MF-1.
//   i_clk   link clock
//   i_rst   synchronous active-high reset (count -> 0)
//   o_cnt   current LMFC position
//   o_wrap  high during the last cycle of a multiframe (o_cnt == MF-1)
// ---------------------------------------------------------------------------
module jesd204b_lmfc_cnt #(
  parameter int MF = 32,
  parameter int W  = (MF > 1) ? $clog2(MF) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == W'(MF - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_cnt <= '0;
    else if (o_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/jesd204b_dll_tx_ctrl.sv
// ---------------------------------------------------------------------------
// jesd204b_dll_tx_ctrl
// JESD204B TX data-link sequencer (SCR=0): CGS -> 4-multiframe ILAS -> DATA,
// driven by SYNC~ and aligned to the local LMFC.
//   i_clk    link clock, one 4-octet word per lane per cycle
//   i_rst    synchronous active-high reset
//   io_link  slave side of jesd204b_dll_tx_ctrl_if (sync_n, tx_datain in;
//            tx_dataout, tx_charisk, tpl_ready, link_state, lmfc_cnt out)
// Octet outputs are registered from the state/LMFC of the previous cycle.
// ---------------------------------------------------------------------------
module jesd204b_dll_tx_ctrl
  import jesd204b_pkg::*;
#(
  parameter int         LANES       = 4,
  parameter int         OCTETS      = 4,
  parameter int         FRAMES_MF   = 32,
  parameter int         CONVERTERS  = 8,
  parameter int         RESOLUTION  = 11,
  parameter int         SAMPLE_SIZE = 16,
  parameter int         CONTROL     = 2,
  parameter int         SAMPLES     = 1,
  parameter logic [7:0] DID         = 8'h00,
  parameter logic [3:0] BID         = 4'h0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  jesd204b_dll_tx_ctrl_if.slave io_link
);
  localparam int MF     = FRAMES_MF * OCTETS / 4;
  localparam int LMFC_W = (MF > 1) ? $clog2(MF) : 1;
  localparam int P_LAST = MF * 4 - 1;

  localparam jesd_cfg_t CFG = '{
    did:   DID,
    bid:   BID,
    l_m1:  5'(LANES - 1),
    f_m1:  8'(OCTETS - 1),
    k_m1:  8'(FRAMES_MF - 1),
    m_m1:  8'(CONVERTERS - 1),
    cs:    2'(CONTROL),
    n_m1:  5'(RESOLUTION - 1),
    np_m1: 5'(SAMPLE_SIZE - 1),
    s_m1:  5'(SAMPLES - 1)
  };

  logic [LMFC_W-1:0] w_lmfc;
  logic              w_lmfc_wrap;

  link_state_e r_state, w_state_nxt;
  logic [1:0]  r_mf_idx, w_mf_idx_nxt;
  logic [1:0]  r_loss_cnt, w_loss_cnt_nxt;
  logic        w_sync_loss;

  logic [LANES-1:0][3:0][7:0] w_oct, r_dout;
  logic [LANES-1:0][3:0]      w_k,   r_k;
  logic                       r_tpl_ready;

  jesd204b_lmfc_cnt #(.MF(MF), .W(LMFC_W)) u_lmfc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_cnt  (w_lmfc),
    .o_wrap (w_lmfc_wrap)
  );

  // ---- state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_CGS;
      r_mf_idx   <= 2'd0;
      r_loss_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mf_idx   <= w_mf_idx_nxt;
      r_loss_cnt <= w_loss_cnt_nxt;
    end
  end

  // ---- next state ----
  // Fourth consecutive low SYNC~ sample drops the link regardless of LMFC.
  assign w_sync_loss = (r_state != ST_CGS) && !io_link.sync_n && (r_loss_cnt == 2'd3);

  always_comb begin
    w_state_nxt    = r_state;
    w_mf_idx_nxt   = r_mf_idx;
    w_loss_cnt_nxt = r_loss_cnt;
    case (r_state)
      ST_CGS: begin
        w_loss_cnt_nxt = 2'd0;
        if (io_link.sync_n && w_lmfc_wrap) begin
          w_state_nxt  = ST_ILAS;
          w_mf_idx_nxt = 2'd0;
        end
      end
      ST_ILAS, ST_DATA: begin
        w_loss_cnt_nxt = io_link.sync_n ? 2'd0 : r_loss_cnt + 2'd1;
        if (w_sync_loss) begin
          w_state_nxt    = ST_CGS;
          w_mf_idx_nxt   = 2'd0;
          w_loss_cnt_nxt = 2'd0;
        end else if (r_state == ST_ILAS && w_lmfc_wrap) begin
          w_mf_idx_nxt = r_mf_idx + 2'd1;
          if (r_mf_idx == 2'd3) w_state_nxt = ST_DATA;
        end
      end
      default: begin
        w_state_nxt    = ST_CGS;
        w_mf_idx_nxt   = 2'd0;
        w_loss_cnt_nxt = 2'd0;
      end
    endcase
  end

  // ---- output decode, per lane / per octet ----
  for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
    for (genvar j = 0; j < 4; j++) begin : g_oct
      int         w_p;      // octet position inside the multiframe
      logic [7:0] w_o;
      logic       w_kc;

      assign w_p = int'(w_lmfc) * 4 + j;

      always_comb begin
        w_o  = K28_5;
        w_kc = 1'b1;
        case (r_state)
          ST_ILAS: begin
            w_o  = 8'(w_p);     // ramp filler
            w_kc = 1'b0;
            if (w_p == 0) begin
              w_o  = K28_0;
              w_kc = 1'b1;
            end else if (w_p == P_LAST) begin
              w_o  = K28_3;
              w_kc = 1'b1;
            end else if (r_mf_idx == 2'd1 && w_p == 1) begin
              w_o  = K28_4;
              w_kc = 1'b1;
            end else if (r_mf_idx == 2'd1 && w_p >= 2 && w_p <= 15) begin
              w_o  = ilas_cfg_octet(CFG, 4'(w_p - 2), 5'(ln));
            end
          end
          ST_DATA: begin
            w_o  = io_link.tx_datain[ln*32 + (3-j)*8 +: 8];
            w_kc = 1'b0;
          end
          default: ;
        endcase
      end

      // octet 0 sits in the MSB byte / MSB K bit of the lane
      assign w_oct[ln][3-j] = w_o;
      assign w_k[ln][3-j]   = w_kc;
    end
  end

  // ---- output registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout      <= {(LANES*4){K28_5}};
      r_k         <= '1;
      r_tpl_ready <= 1'b0;
    end else begin
      r_dout      <= w_oct;
      r_k         <= w_k;
      r_tpl_ready <= (w_state_nxt == ST_DATA);
    end
  end

  assign io_link.tx_dataout = r_dout;
  assign io_link.tx_charisk = r_k;
  assign io_link.tpl_ready  = r_tpl_ready;
  assign io_link.link_state = r_state;
  assign io_link.lmfc_cnt   = w_lmfc;

endmodule
